// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential shift-add multiplier: FSM state encoding and counter sizing.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Control FSM and bit counter: IDLE accepts start, RUN lasts WIDTH cycles, DONE lasts one cycle.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic load,
  output logic step,
  output logic finish,
  output logic busy
);

  localparam int CW = cnt_width(WIDTH);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, fixed WIDTH+2 cycle issue interval.
// Define SEQ_MULT_SIGNED_EN to honour signed_op (magnitude multiply, negate on completion).
module seq_mult_param
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_op,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy,
  output logic               done
);

  localparam int AW = 2 * WIDTH + 1;

  logic             load, step, finish;
  logic [AW-1:0]    acc, mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] result;
  logic             unused_acc_msb;

  seq_mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .load   (load),
    .step   (step),
    .finish (finish),
    .busy   (busy)
  );

`ifdef SEQ_MULT_SIGNED_EN
  logic neg_in, neg;

  // Magnitude of the most negative value still fits in WIDTH unsigned bits.
  always_comb begin
    a_mag  = (signed_op && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag  = (signed_op && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    neg_in = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     neg <= 1'b0;
    else if (load) neg <= neg_in;
  end

  assign result = neg ? (~acc[2*WIDTH-1:0] + (2*WIDTH)'(1)) : acc[2*WIDTH-1:0];
`else
  logic unused_signed_op;

  assign a_mag            = a;
  assign b_mag            = b;
  assign unused_signed_op = signed_op;
  assign result           = acc[2*WIDTH-1:0];
`endif

  assign unused_acc_msb = acc[AW-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      done   <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        acc    <= '0;
        mcand  <= AW'(a_mag);
        mplier <= b_mag;
      end else if (step) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
      if (finish) prod <= result;
    end
  end

endmodule
